// File: rtl/lcd_frame_sched.sv
// ----------------------------------------------------------------------------
// lcd_frame_sched
//   Frame scheduler in the LCD pixel-clock domain. Waits for the pixel FIFO
//   to be primed and for the driver's frame start, then forwards one FIFO
//   read per driver request until a full frame has been streamed. On an
//   underflow or a premature frame start it drains the FIFO and asks the
//   upstream writer to restart at pixel 0.
//
//   State table
//     state    | meaning
//     ---------+----------------------------------------------------------
//     IDLE  0  | disabled; no reads
//     ARMED 1  | waiting for frame_start with enough data buffered
//     STREAM 2 | one FIFO read per lcd_request, counting pixels
//     FLUSH 3  | discarding stale FIFO contents until empty
//
//   Ports
//     i_clk           LCD pixel clock
//     i_rst_n         asynchronous active-low reset
//     i_enable        scheduler enable (level)
//     i_frame_start   one-cycle pulse at vertical sync
//     i_lcd_request   driver wants a pixel this cycle
//     i_fifo_empty    FIFO empty flag (FWFT: data valid while not empty)
//     i_fifo_rd_cnt   FIFO read-side occupancy
//     o_fifo_rd_en    FIFO read enable / pixel qualifier
//     o_pix_valid     pixel data is real (0 -> driver shows black)
//     o_lcd_framesync one-cycle restart pulse to upstream
//     o_state         current state encoding (see table)
//     o_frame_cnt     completed frames, wrapping
//     o_underflow_cnt underflow / sync-loss events, saturating
//     o_skip_cnt      frames skipped for low FIFO level, saturating
// ----------------------------------------------------------------------------
module lcd_frame_sched #(
    parameter int H_DISP      = 480,
    parameter int V_DISP      = 272,
    parameter int START_LEVEL = 64,
    parameter int CNT_W       = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_frame_start,
    input  logic             i_lcd_request,
    input  logic             i_fifo_empty,
    input  logic [CNT_W-1:0] i_fifo_rd_cnt,
    output logic             o_fifo_rd_en,
    output logic             o_pix_valid,
    output logic             o_lcd_framesync,
    output logic [1:0]       o_state,
    output logic [15:0]      o_frame_cnt,
    output logic [7:0]       o_underflow_cnt,
    output logic [7:0]       o_skip_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [16:0]      LAST_PIX  = 17'(H_DISP * V_DISP - 1);
    localparam logic [CNT_W-1:0] START_LVL = CNT_W'(START_LEVEL);

    state_t      r_state;
    logic [16:0] r_pix_cnt;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_underflow_cnt;
    logic [7:0]  r_skip_cnt;
    logic        r_framesync;

    logic w_read;
    logic w_discard;
    logic w_underflow;

    // Reads are gated by enable so a disable stops the FIFO in the same cycle.
    assign w_read      = i_enable & (r_state == S_STREAM) & i_lcd_request & ~i_fifo_empty;
    assign w_discard   = i_enable & (r_state == S_FLUSH) & ~i_fifo_empty;
    assign w_underflow = (r_state == S_STREAM) & i_lcd_request & i_fifo_empty;

    assign o_fifo_rd_en    = w_read | w_discard;
    assign o_pix_valid     = w_read;
    assign o_lcd_framesync = r_framesync;
    assign o_state         = r_state;
    assign o_frame_cnt     = r_frame_cnt;
    assign o_underflow_cnt = r_underflow_cnt;
    assign o_skip_cnt      = r_skip_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_pix_cnt       <= '0;
            r_frame_cnt     <= '0;
            r_underflow_cnt <= '0;
            r_skip_cnt      <= '0;
            r_framesync     <= 1'b0;
        end else begin
            r_framesync <= 1'b0;
            if (!i_enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state     <= S_ARMED;
                        r_framesync <= 1'b1;
                    end
                    S_ARMED: begin
                        if (i_frame_start) begin
                            if (i_fifo_rd_cnt >= START_LVL) begin
                                r_state   <= S_STREAM;
                                r_pix_cnt <= '0;
                            end else if (r_skip_cnt != 8'hFF) begin
                                r_skip_cnt <= r_skip_cnt + 8'd1;
                            end
                        end
                    end
                    S_STREAM: begin
                        // Underflow outranks a coincident frame_start so the
                        // event is counted once; a last-pixel read outranks
                        // frame_start so the frame still completes.
                        if (w_underflow) begin
                            r_state <= S_FLUSH;
                            if (r_underflow_cnt != 8'hFF)
                                r_underflow_cnt <= r_underflow_cnt + 8'd1;
                        end else if (w_read && (r_pix_cnt == LAST_PIX)) begin
                            r_state     <= S_ARMED;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else if (i_frame_start) begin
                            r_state <= S_FLUSH;
                            if (r_underflow_cnt != 8'hFF)
                                r_underflow_cnt <= r_underflow_cnt + 8'd1;
                        end else if (w_read) begin
                            r_pix_cnt <= r_pix_cnt + 17'd1;
                        end
                    end
                    S_FLUSH: begin
                        if (i_fifo_empty) begin
                            r_state     <= S_ARMED;
                            r_framesync <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_sched.sv
module tb_lcd_frame_sched;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int TOTAL = H * V;
    localparam int START = 64;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          frame_start;
    logic          lcd_request;
    logic          fifo_empty;
    logic [CW-1:0] fifo_rd_cnt;
    logic          fifo_rd_en;
    logic          pix_valid;
    logic          lcd_framesync;
    logic [1:0]    state;
    logic [15:0]   frame_cnt;
    logic [7:0]    underflow_cnt;
    logic [7:0]    skip_cnt;

    lcd_frame_sched #(
        .H_DISP(H), .V_DISP(V), .START_LEVEL(START), .CNT_W(CW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(enable),
        .i_frame_start(frame_start),
        .i_lcd_request(lcd_request),
        .i_fifo_empty(fifo_empty),
        .i_fifo_rd_cnt(fifo_rd_cnt),
        .o_fifo_rd_en(fifo_rd_en),
        .o_pix_valid(pix_valid),
        .o_lcd_framesync(lcd_framesync),
        .o_state(state),
        .o_frame_cnt(frame_cnt),
        .o_underflow_cnt(underflow_cnt),
        .o_skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    int tests   = 0;
    int fails   = 0;
    int rd_seen = 0;

    // Behavioural model: phase of the frame and event tallies.
    int m_mode;     // 0 off, 1 waiting for frame, 2 streaming, 3 draining
    int m_pixels;   // pixels delivered in the current frame
    int m_frames;
    int m_unders;
    int m_skips;
    bit m_sync;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pixels = 0; m_frames = 0; m_unders = 0; m_skips = 0; m_sync = 0;
    endtask

    task automatic model_compare();
        bit delivering, draining;
        delivering = enable && m_mode == 2 && lcd_request && !fifo_empty;
        draining   = enable && m_mode == 3 && !fifo_empty;
        check("m_rd_en", {31'd0, fifo_rd_en}, {31'd0, delivering | draining});
        check("m_pix_valid", {31'd0, pix_valid}, {31'd0, delivering});
        check("m_framesync", {31'd0, lcd_framesync}, {31'd0, m_sync});
        check("m_state", {30'd0, state}, m_mode);
        check("m_frame_cnt", {16'd0, frame_cnt}, m_frames % 65536);
        check("m_underflow_cnt", {24'd0, underflow_cnt}, m_unders);
        check("m_skip_cnt", {24'd0, skip_cnt}, m_skips);
    endtask

    task automatic model_advance();
        bit starved, last;
        starved = lcd_request && fifo_empty;
        last    = lcd_request && !fifo_empty && (m_pixels == TOTAL - 1);
        m_sync  = 0;
        if (!enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_sync = 1;
        end else if (m_mode == 1) begin
            if (frame_start) begin
                if (int'(fifo_rd_cnt) >= START) begin
                    m_mode   = 2;
                    m_pixels = 0;
                end else begin
                    m_skips = sat8(m_skips + 1);
                end
            end
        end else if (m_mode == 2) begin
            if (starved) begin
                m_unders = sat8(m_unders + 1);
                m_mode   = 3;
            end else if (last) begin
                m_frames = m_frames + 1;
                m_mode   = 1;
            end else if (frame_start) begin
                m_unders = sat8(m_unders + 1);
                m_mode   = 3;
            end else if (lcd_request) begin
                m_pixels = m_pixels + 1;
            end
        end else begin
            if (fifo_empty) begin
                m_mode = 1;
                m_sync = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            model_compare();
        end else begin
            model_compare();
            if (fifo_rd_en) rd_seen++;
            model_advance();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        model_reset();
        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; lcd_request = 1'b0;
        fifo_empty = 1'b0; fifo_rd_cnt = 10'd100;

        // Reset and enable
        #2;
        check("rst_state", {30'd0, state}, 0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("en_state", {30'd0, state}, 1);
        check("en_framesync", {31'd0, lcd_framesync}, 1);
        check("en_counters", {frame_cnt, underflow_cnt, skip_cnt}, 0);
        step();
        check("en_framesync_drop", {31'd0, lcd_framesync}, 0);
        lcd_request = 1'b1;
        #1;
        check("armed_no_read", {31'd0, fifo_rd_en}, 0);
        lcd_request = 1'b0;

        // Full frame
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; lcd_request = 1'b1;
        base = rd_seen;
        repeat (TOTAL) step();
        lcd_request = 1'b0;
        check("full_reads", rd_seen - base, TOTAL);
        check("full_frame_cnt", {16'd0, frame_cnt}, 1);
        check("full_state", {30'd0, state}, 1);

        // Last-pixel read coincident with frame_start
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; lcd_request = 1'b1;
        repeat (TOTAL - 1) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; lcd_request = 1'b0;
        check("last_fs_frame_cnt", {16'd0, frame_cnt}, 2);
        check("last_fs_state", {30'd0, state}, 1);
        step();
        check("last_fs_not_consumed", {30'd0, state}, 1);

        // Low FIFO level at frame start
        step();
        frame_start = 1'b1; fifo_rd_cnt = 10'd63;
        step();
        check("low_skip_cnt", {24'd0, skip_cnt}, 1);
        check("low_state", {30'd0, state}, 1);
        fifo_rd_cnt = 10'd64;
        step();
        frame_start = 1'b0;
        check("level64_state", {30'd0, state}, 2);
        check("level64_skip_held", {24'd0, skip_cnt}, 1);

        // Underflow, then drain five words
        lcd_request = 1'b1;
        repeat (10) step();
        fifo_empty = 1'b1;
        #1;
        check("uf_pix_valid", {31'd0, pix_valid}, 0);
        check("uf_rd_en", {31'd0, fifo_rd_en}, 0);
        step();
        fifo_empty = 1'b0;
        base = rd_seen;
        check("uf_state_flush", {30'd0, state}, 3);
        check("uf_count", {24'd0, underflow_cnt}, 1);
        repeat (5) step();
        fifo_empty = 1'b1;
        check("uf_drained", rd_seen - base, 5);
        step();
        check("uf_resync_state", {30'd0, state}, 1);
        check("uf_resync_pulse", {31'd0, lcd_framesync}, 1);
        lcd_request = 1'b0; fifo_empty = 1'b0;
        step();
        check("uf_resync_drop", {31'd0, lcd_framesync}, 0);

        // Underflow coincident with frame_start counts once; FLUSH ignores frame_start
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; lcd_request = 1'b1;
        step();
        frame_start = 1'b1; fifo_empty = 1'b1;
        step();
        frame_start = 1'b0; fifo_empty = 1'b0; lcd_request = 1'b0;
        check("uf_fs_once", {24'd0, underflow_cnt}, 2);
        check("uf_fs_state", {30'd0, state}, 3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("flush_ignores_fs", {30'd0, state}, 3);
        fifo_empty = 1'b1;
        step();
        fifo_empty = 1'b0;
        check("flush_exit", {30'd0, state}, 1);

        // Repeated sync loss saturates the underflow counter
        for (int i = 0; i < 300; i++) begin
            frame_start = 1'b1; fifo_rd_cnt = 10'd100;
            step();
            frame_start = 1'b0; lcd_request = 1'b1;
            step();
            step();
            frame_start = 1'b1;
            step();
            frame_start = 1'b0; lcd_request = 1'b0; fifo_empty = 1'b1;
            step();
            fifo_empty = 1'b0;
        end
        check("sync_loss_sat", {24'd0, underflow_cnt}, 255);
        check("sync_loss_state", {30'd0, state}, 1);

        // Disable mid-stream
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; lcd_request = 1'b1;
        step();
        step();
        enable = 1'b0;
        #1;
        check("dis_rd_en", {31'd0, fifo_rd_en}, 0);
        check("dis_pix_valid", {31'd0, pix_valid}, 0);
        step();
        check("dis_state", {30'd0, state}, 0);
        check("dis_frame_held", {16'd0, frame_cnt}, 2);
        enable = 1'b1;
        step();
        check("reen_state", {30'd0, state}, 1);
        check("reen_framesync", {31'd0, lcd_framesync}, 1);

        // Asynchronous reset mid-frame
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", {30'd0, state}, 0);
        check("arst_rd_en", {31'd0, fifo_rd_en}, 0);
        check("arst_pix_valid", {31'd0, pix_valid}, 0);
        check("arst_framesync", {31'd0, lcd_framesync}, 0);
        check("arst_counters", {frame_cnt, underflow_cnt, skip_cnt}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_rearm", {30'd0, state}, 1);
        lcd_request = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_frame_sched.md
Name: lcd_frame_sched

Overview:
- Frame scheduler in the LCD pixel-clock domain that sequences reads from the AXI-stream-to-LCD pixel FIFO into the LCD driver.
- Waits until the FIFO is primed, aligns streaming to the driver's frame start, and counts pixels per frame.
- On underflow or sync loss, it flushes stale data and pulses a frame-resync to the upstream write side.
- Sits between the FIFO read port and the LCD driver's request/data interface.

Parameters:
- H_DISP, 480, active pixels per line.
- V_DISP, 272, active lines per frame.
- START_LEVEL, 64, minimum fifo_rd_cnt required at frame start to begin streaming.
- CNT_W, 10, width of fifo_rd_cnt.

Ports:
- clk  input  1  LCD pixel clock; the only clock.
- rst_n  input  1  Asynchronous, active-low reset.
- enable  input  1  Scheduler enable; level-sensitive.
- frame_start  input  1  One-cycle pulse from the driver at the start of vertical sync.
- lcd_request  input  1  Driver requests one pixel this cycle (active display region).
- fifo_empty  input  1  FIFO empty flag. The FIFO is first-word-fall-through, so data is valid while not empty.
- fifo_rd_cnt  input  CNT_W  FIFO read-side occupancy.
- fifo_rd_en  output  1  FIFO read enable; also qualifies the pixel data to the driver.
- pix_valid  output  1  Pixel data is real; 0 means the driver outputs black.
- lcd_framesync  output  1  One-cycle registered pulse telling upstream to restart at pixel 0.
- state  output  2  Current state: 0=IDLE, 1=ARMED, 2=STREAM, 3=FLUSH.
- frame_cnt  output  16  Completed frames; wraps.
- underflow_cnt  output  8  Underflow/sync-loss events; saturates at 255.
- skip_cnt  output  8  Frames skipped for an insufficient FIFO level; saturates at 255.

Behaviour:
- Reset: all outputs are 0, state=IDLE, and the internal pix_cnt (17 bits, H_DISP*V_DISP-1 max) is 0. Reset takes effect immediately and asynchronously, including mid-frame.
- fifo_rd_en and pix_valid are combinational from the registered state and the inputs. All counters and lcd_framesync are registered.
- IDLE:
  - fifo_rd_en=0.
  - When enable=1: go to ARMED next cycle and pulse lcd_framesync for 1 cycle.
- ARMED:
  - fifo_rd_en=0.
  - On frame_start with fifo_rd_cnt>=START_LEVEL: go to STREAM and clear pix_cnt.
  - On frame_start with fifo_rd_cnt<START_LEVEL: skip_cnt+1 (saturating), stay in ARMED.
- STREAM:
  - fifo_rd_en = pix_valid = lcd_request & ~fifo_empty.
  - Each read increments pix_cnt.
  - A read with pix_cnt==H_DISP*V_DISP-1 completes the frame: frame_cnt+1, go to ARMED.
  - lcd_request & fifo_empty is an underflow: underflow_cnt+1 (saturating), go to FLUSH. No read that cycle; the driver shows black.
  - frame_start before the frame completes is a sync loss: counted in underflow_cnt, go to FLUSH.
- FLUSH:
  - fifo_rd_en = ~fifo_empty (discard); pix_valid=0.
  - When fifo_empty=1: pulse lcd_framesync and go to ARMED.
  - lcd_request is ignored.
- enable=0 in any state forces IDLE next cycle. fifo_rd_en goes to 0 in that same cycle (combinationally gated by enable). Counters hold their values.
- Simultaneous events:
  - Underflow and frame_start in the same STREAM cycle: count underflow_cnt once only, go to FLUSH.
  - Last-pixel read and frame_start in the same cycle: the frame completes (frame_cnt+1) and that frame_start is NOT consumed; ARMED waits for the next frame_start.
  - frame_start while in FLUSH is ignored.
- Latency:
  - frame_start to first possible read: 1 cycle (state register).
  - Underflow to lcd_framesync: at least 2 cycles (enter FLUSH, then the empty check).

Test Plan:
- Reset/enable: release rst_n with enable=1 -> lcd_framesync pulses exactly 1 cycle and state=1. All counters are 0 and fifo_rd_en stays 0 until frame_start.
- Full frame: FIFO model never empty, rd_cnt=100, frame_start, then lcd_request for 130560 cycles -> exactly 130560 rd_en pulses, frame_cnt=1, state=1 afterwards.
- Low level: frame_start with rd_cnt=63 -> skip_cnt=1, no reads, state stays 1. Next frame_start with rd_cnt=64 -> state=2.
- Underflow: empty=1 at pixel 1000 while lcd_request=1 -> underflow_cnt=1, pix_valid=0 that cycle, FLUSH drains 5 queued words, then lcd_framesync pulse and state=1.
- Sync loss: frame_start at pixel 50000 in STREAM -> underflow_cnt+1, FLUSH. Repeat 300 times -> underflow_cnt saturates at 255.
- Mid-stream disable/reset: drop enable during STREAM -> rd_en=0 the same cycle, state=0 next cycle, frame_cnt held. Assert rst_n=0 asynchronously mid-frame -> all outputs 0 immediately.
